// File: rtl/arm_pio_pkg.sv
// -----------------------------------------------------------------------------
// arm_pio_pkg
// Shared definitions for the HPS-to-FPGA bidirectional PIO:
//   - register word addresses (3-bit Avalon word address)
//   - edge-detect selection enum (rising / falling / any)
//   - CPU-visible register width
// Optional feature macro used by the top: ARM_PIO_BITSET_EN (OUTSET/OUTCLEAR).
// -----------------------------------------------------------------------------
package arm_pio_pkg;

    localparam int PIO_REG_W = 32;

    localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
    localparam logic [2:0] PIO_ADDR_DIR     = 3'd1;
    localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/arm_pio_gen_if.sv
// -----------------------------------------------------------------------------
// arm_pio_gen_if
// Avalon-MM slave bus bundle for the PIO (fixed zero-wait read and write).
//   address    3-bit register word address
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  32-bit write data
//   readdata   32-bit read data, combinational from the register file
// Modports: master (bus host / testbench), slave (the PIO).
// -----------------------------------------------------------------------------
interface arm_pio_gen_if;
    import arm_pio_pkg::*;

    logic [2:0]           address;
    logic                 chipselect;
    logic                 write_n;
    logic [PIO_REG_W-1:0] writedata;
    logic [PIO_REG_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/arm_pio_sync_edge.sv
// -----------------------------------------------------------------------------
// arm_pio_sync_edge
// WIDTH-wide input synchroniser (SYNC_STAGES flops) followed by one "prev"
// flop; per-bit edge detect between the last sync stage and prev.
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset (clears all flops)
//   in_port   asynchronous external inputs
//   in_sync   synchronised inputs (last sync stage)
//   edge_det  one-cycle edge pulse per bit, type selected by EDGE_TYPE
// -----------------------------------------------------------------------------
module arm_pio_sync_edge
    import arm_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
            prev_reg <= '0;
        end else begin
            sync_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign in_sync = sync_reg[SYNC_STAGES-1];

    // Edge type is fixed at elaboration, so only one detector per bit is built.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
                assign edge_det[gi] = ~in_sync[gi] & prev_reg[gi];
            end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_any
                assign edge_det[gi] = in_sync[gi] ^ prev_reg[gi];
            end else begin : g_rise
                assign edge_det[gi] = in_sync[gi] & ~prev_reg[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/arm_pio_gen.sv
// -----------------------------------------------------------------------------
// arm_pio_gen
// Parametrised Avalon-MM bidirectional PIO: per-bit direction, synchronised
// inputs, sticky edge capture with per-bit IRQ mask, single level irq.
// Register map (word addresses):
//   0 DATA      W: data_out   R: per bit dir ? data_out : in_sync
//   1 DIRECTION 1 = output, 0 = input
//   2 IRQMASK
//   3 EDGECAPTURE  R, write-1-to-clear
//   4 OUTSET   (only with ARM_PIO_BITSET_EN) data_out |= writedata, reads 0
//   5 OUTCLEAR (only with ARM_PIO_BITSET_EN) data_out &= ~writedata, reads 0
//   other addresses read 0, writes ignored
// Optional feature macro: ARM_PIO_BITSET_EN
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       Avalon slave (address/chipselect/write_n/writedata/readdata)
//   in_port   asynchronous external inputs
//   out_port  output data register
//   oe        output enable (direction register)
//   irq       |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module arm_pio_gen
    import arm_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    arm_pio_gen_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic [WIDTH-1:0] dir_reg,      dir_next;
    logic [WIDTH-1:0] irqmask_reg,  irqmask_next;
    logic [WIDTH-1:0] edgecap_reg,  edgecap_next;

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_val;
    logic             wr_en;
    logic             unused_wdata;

    arm_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately ignored.
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        irqmask_next  = irqmask_reg;
        edgecap_next  = edgecap_reg;
        if (wr_en) begin
            case (bus.address)
                PIO_ADDR_DATA:    data_out_next = wdata;
                PIO_ADDR_DIR:     dir_next      = wdata;
                PIO_ADDR_IRQMASK: irqmask_next  = wdata;
                PIO_ADDR_EDGECAP: edgecap_next  = edgecap_reg & ~wdata;
`ifdef ARM_PIO_BITSET_EN
                PIO_ADDR_OUTSET:  data_out_next = data_out_reg | wdata;
                PIO_ADDR_OUTCLR:  data_out_next = data_out_reg & ~wdata;
`endif
                default: ;
            endcase
        end
        // New edges are OR'ed in after the clear so a same-cycle edge wins.
        // Only input bits capture; existing captures survive a direction change.
        edgecap_next = edgecap_next | (edge_det & ~dir_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= OUT_RESET;
            dir_reg      <= DIR_RESET;
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
        end else begin
            data_out_reg <= data_out_next;
            dir_reg      <= dir_next;
            irqmask_reg  <= irqmask_next;
            edgecap_reg  <= edgecap_next;
        end
    end

    // Zero-wait read mux; reads never alter state.
    always_comb begin
        rd_val = '0;
        case (bus.address)
            PIO_ADDR_DATA:    rd_val = (dir_reg & data_out_reg) | (~dir_reg & in_sync);
            PIO_ADDR_DIR:     rd_val = dir_reg;
            PIO_ADDR_IRQMASK: rd_val = irqmask_reg;
            PIO_ADDR_EDGECAP: rd_val = edgecap_reg;
            default:          rd_val = '0;
        endcase
        bus.readdata              = '0;
        bus.readdata[WIDTH-1:0]   = rd_val;
    end

    assign out_port = data_out_reg;
    assign oe       = dir_reg;
    assign irq      = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_arm_pio_gen.sv
// -----------------------------------------------------------------------------
// tb_arm_pio_gen
// Directed bench for arm_pio_gen. Two 8-bit instances:
//   dut_a: OUT_RESET 0x00, DIR_RESET 0xFF, rising-edge capture
//   dut_b: OUT_RESET 0x5A, DIR_RESET 0x0F, falling-edge capture
// -----------------------------------------------------------------------------
module tb_arm_pio_gen;
    import arm_pio_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_a, out_a, oe_a;
    logic [7:0] in_b, out_b, oe_b;
    logic       irq_a, irq_b;
    logic [31:0] v;

    int tests_run = 0;
    int tests_failed = 0;

    arm_pio_gen_if bus_a();
    arm_pio_gen_if bus_b();

    arm_pio_gen #(
        .WIDTH(8), .OUT_RESET(8'h00), .DIR_RESET(8'hFF), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .in_port(in_a), .out_port(out_a), .oe(oe_a), .irq(irq_a)
    );

    arm_pio_gen #(
        .WIDTH(8), .OUT_RESET(8'h5A), .DIR_RESET(8'h0F), .EDGE_TYPE(1), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .in_port(in_b), .out_port(out_b), .oe(oe_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel_b, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel_b) begin
            bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end else begin
            bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end
        @(posedge clk);
        #1;
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    task automatic rd(input bit sel_b, input logic [2:0] a, output logic [31:0] d);
        if (sel_b) begin
            bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
            #1 d = bus_b.readdata;
            bus_b.chipselect = 1'b0;
        end else begin
            bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
            #1 d = bus_a.readdata;
            bus_a.chipselect = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_a = 8'h00;
        in_b = 8'hF0;
        bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        cyc(2);
        @(negedge clk) reset_n = 1'b1;
        cyc(1);

        // Reset asserted in the middle of a DIRECTION write
        wr(0, PIO_ADDR_DATA, 32'h77);
        chk("pre_reset_out", {24'h0, out_a}, 32'h77);
        @(negedge clk);
        bus_a.address = PIO_ADDR_DIR; bus_a.writedata = 32'h0; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_a", {24'h0, out_a}, 32'h00);
        chk("rst_oe_a", {24'h0, oe_a}, 32'hFF);
        chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
        chk("rst_out_b", {24'h0, out_b}, 32'h5A);
        chk("rst_oe_b", {24'h0, oe_b}, 32'h0F);
        @(posedge clk); #1;
        chk("rst_hold_oe_a", {24'h0, oe_a}, 32'hFF);
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        rd(0, PIO_ADDR_DATA, v);    chk("rst_rd_data", v, 32'h00);
        rd(0, PIO_ADDR_DIR, v);     chk("rst_rd_dir", v, 32'hFF);
        rd(0, PIO_ADDR_IRQMASK, v); chk("rst_rd_mask", v, 32'h00);
        rd(0, PIO_ADDR_EDGECAP, v); chk("rst_rd_ecap", v, 32'h00);
        @(negedge clk) reset_n = 1'b1;
        cyc(1);
        chk("post_rst_oe_a", {24'h0, oe_a}, 32'hFF);

        // Upper writedata bits ignored, readdata zero-extended
        wr(0, PIO_ADDR_DATA, 32'hFFFF_FFA5);
        chk("wr_data_out", {24'h0, out_a}, 32'hA5);
        rd(0, PIO_ADDR_DATA, v); chk("rd_data_a5", v, 32'h0000_00A5);

        // Mixed direction read-back and synchroniser latency
        wr(0, PIO_ADDR_DIR, 32'h0F);
        chk("oe_0f", {24'h0, oe_a}, 32'h0F);
        @(negedge clk) in_a = 8'h30;
        cyc(1);
        rd(0, PIO_ADDR_DATA, v); chk("rd_mixed_1cyc", v, 32'h05);
        cyc(1);
        rd(0, PIO_ADDR_DATA, v); chk("rd_mixed_2cyc", v, 32'h35);
        cyc(1);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_bits45", v, 32'h30);
        wr(0, PIO_ADDR_EDGECAP, 32'hFF);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_clr_all", v, 32'h00);

        // Rising edge capture timing and irq
        wr(0, PIO_ADDR_DIR, 32'h00);
        @(negedge clk) in_a = 8'h00;
        cyc(4);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_no_fall", v, 32'h00);
        wr(0, PIO_ADDR_IRQMASK, 32'h01);
        @(negedge clk) in_a = 8'h01;
        cyc(2);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_2cyc", v, 32'h00);
        chk("irq_2cyc", {31'h0, irq_a}, 32'h0);
        cyc(1);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_3cyc", v, 32'h01);
        chk("irq_3cyc", {31'h0, irq_a}, 32'h1);
        wr(0, PIO_ADDR_EDGECAP, 32'h01);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_w1c", v, 32'h00);
        chk("irq_w1c", {31'h0, irq_a}, 32'h0);

        // W1C in the same cycle as a new edge: the set wins
        @(negedge clk) in_a = 8'h00;
        cyc(4);
        @(negedge clk) in_a = 8'h01;
        cyc(2);
        wr(0, PIO_ADDR_EDGECAP, 32'h01);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_set_wins", v, 32'h01);
        wr(0, PIO_ADDR_DIR, 32'h01);
        rd(0, PIO_ADDR_EDGECAP, v); chk("ecap_dir_keep", v, 32'h01);
        wr(0, PIO_ADDR_DIR, 32'h00);

        // Falling-edge instance: masked capture, then unmask
        rd(1, PIO_ADDR_EDGECAP, v); chk("b_no_rise_cap", v, 32'h00);
        rd(1, PIO_ADDR_DATA, v);    chk("b_rd_data", v, 32'hFA);
        @(negedge clk) in_b = 8'hE0;
        cyc(2);
        rd(1, PIO_ADDR_EDGECAP, v); chk("b_ecap_2cyc", v, 32'h00);
        cyc(1);
        rd(1, PIO_ADDR_EDGECAP, v); chk("b_ecap_fall", v, 32'h10);
        chk("b_irq_masked", {31'h0, irq_b}, 32'h0);
        @(negedge clk) in_b = 8'hE1;
        cyc(4);
        @(negedge clk) in_b = 8'hE0;
        cyc(4);
        rd(1, PIO_ADDR_EDGECAP, v); chk("b_out_bit_nocap", v, 32'h10);
        wr(1, PIO_ADDR_IRQMASK, 32'h10);
        chk("b_irq_unmask", {31'h0, irq_b}, 32'h1);

        // Bit set/clear and unmapped addresses
        wr(0, PIO_ADDR_DATA, 32'h0F);
        wr(0, PIO_ADDR_OUTSET, 32'hF0);
`ifdef ARM_PIO_BITSET_EN
        chk("outset", {24'h0, out_a}, 32'hFF);
`else
        chk("outset", {24'h0, out_a}, 32'h0F);
`endif
        wr(0, PIO_ADDR_OUTCLR, 32'h3C);
`ifdef ARM_PIO_BITSET_EN
        chk("outclr", {24'h0, out_a}, 32'hC3);
`else
        chk("outclr", {24'h0, out_a}, 32'h0F);
`endif
        rd(0, PIO_ADDR_OUTSET, v); chk("rd_addr4", v, 32'h0);
        wr(0, 3'd6, 32'hFF);
        rd(0, 3'd6, v); chk("rd_addr6", v, 32'h0);
        rd(0, PIO_ADDR_DIR, v); chk("addr6_no_dir", v, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
